// File: rtl/branch_predictor.sv
// Fetch-stage direction predictor: direct-mapped table of 2-bit saturating
// counters plus a tagged target buffer, trained by execute-stage resolutions.
module branch_predictor #(
   parameter int INDEX_BITS = 6,
   parameter int TAG_BITS   = 32 - INDEX_BITS - 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] fetch_pc_i,
   output logic        predict_taken_o,
   output logic [31:0] predict_target_o,
   input  logic        execute_is_branch_i,
   input  logic        execute_branch_taken_i,
   input  logic        branch_mispredict_i,
   input  logic [31:0] execute_pc_i,
   input  logic [31:0] execute_target_i,
   output logic [31:0] branch_count_o,
   output logic [31:0] mispredict_count_o
);

   localparam int unsigned ENTRIES = 1 << INDEX_BITS;

   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } ctr_t;

   ctr_t                ctr     [ENTRIES];
   logic                valid   [ENTRIES];
   logic [TAG_BITS-1:0] tags    [ENTRIES];
   logic [31:0]         targets [ENTRIES];

   logic [31:0] branch_count;
   logic [31:0] mispredict_count;

   logic [INDEX_BITS-1:0] fetch_idx;
   logic [TAG_BITS-1:0]   fetch_tag;
   logic [INDEX_BITS-1:0] exec_idx;
   logic [TAG_BITS-1:0]   exec_tag;
   logic                  hit;
   ctr_t                  ctr_next;

   // Low PC bits are always zero for aligned instructions and carry no index/tag information.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{fetch_pc_i[1:0], execute_pc_i[1:0]};

   assign fetch_idx = fetch_pc_i[INDEX_BITS+1:2];
   assign fetch_tag = fetch_pc_i[31:INDEX_BITS+2];
   assign exec_idx  = execute_pc_i[INDEX_BITS+1:2];
   assign exec_tag  = execute_pc_i[31:INDEX_BITS+2];

   always_comb begin
      hit              = valid[fetch_idx] && (tags[fetch_idx] == fetch_tag);
      predict_taken_o  = hit && ((ctr[fetch_idx] == WEAK_T) || (ctr[fetch_idx] == STRONG_T));
      predict_target_o = predict_taken_o ? targets[fetch_idx] : fetch_pc_i + 32'd4;
   end

   // Counter trains on the index alone; the tag only gates the prediction.
   always_comb begin
      ctr_next = ctr[exec_idx];
      unique case (ctr[exec_idx])
         STRONG_NT: ctr_next = execute_branch_taken_i ? WEAK_NT  : STRONG_NT;
         WEAK_NT:   ctr_next = execute_branch_taken_i ? WEAK_T   : STRONG_NT;
         WEAK_T:    ctr_next = execute_branch_taken_i ? STRONG_T : WEAK_NT;
         STRONG_T:  ctr_next = execute_branch_taken_i ? STRONG_T : WEAK_T;
         default:   ctr_next = WEAK_NT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            ctr[INDEX_BITS'(i)]     <= WEAK_NT;
            valid[INDEX_BITS'(i)]   <= 1'b0;
            tags[INDEX_BITS'(i)]    <= '0;
            targets[INDEX_BITS'(i)] <= '0;
         end
         branch_count     <= '0;
         mispredict_count <= '0;
      end else if (execute_is_branch_i) begin
         ctr[exec_idx] <= ctr_next;
         if (execute_branch_taken_i) begin
            valid[exec_idx]   <= 1'b1;
            tags[exec_idx]    <= exec_tag;
            targets[exec_idx] <= execute_target_i;
         end
         branch_count <= branch_count + 32'd1;
         if (branch_mispredict_i)
            mispredict_count <= mispredict_count + 32'd1;
      end
   end

   assign branch_count_o     = branch_count;
   assign mispredict_count_o = mispredict_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] fetch_pc;
   logic        predict_taken;
   logic [31:0] predict_target;
   logic        is_branch;
   logic        branch_taken;
   logic        mispredict;
   logic [31:0] exec_pc;
   logic [31:0] exec_target;
   logic [31:0] branch_count;
   logic [31:0] mispredict_count;

   int passed = 0;
   int total  = 0;

   branch_predictor #(.INDEX_BITS(6)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .fetch_pc_i             (fetch_pc),
      .predict_taken_o        (predict_taken),
      .predict_target_o       (predict_target),
      .execute_is_branch_i    (is_branch),
      .execute_branch_taken_i (branch_taken),
      .branch_mispredict_i    (mispredict),
      .execute_pc_i           (exec_pc),
      .execute_target_i       (exec_target),
      .branch_count_o         (branch_count),
      .mispredict_count_o     (mispredict_count)
   );

   always #5 clk = ~clk;

   // Reference model: counters as plain integers 0..3, saturating with min/max.
   int          m_ctr   [64];
   bit          m_valid [64];
   logic [23:0] m_tag   [64];
   logic [31:0] m_tgt   [64];
   logic [31:0] m_bc;
   logic [31:0] m_mc;

   function automatic void model_reset();
      for (int i = 0; i < 64; i++) begin
         m_ctr[i] = 1; m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0;
      end
      m_bc = '0;
      m_mc = '0;
   endfunction

   function automatic void model_update(input logic br, input logic tk, input logic mis,
                                        input logic [31:0] pc, input logic [31:0] tgt);
      int idx;
      if (!br) return;
      idx = int'(pc[7:2]);
      if (tk) begin
         m_ctr[idx]   = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
         m_valid[idx] = 1;
         m_tag[idx]   = pc[31:8];
         m_tgt[idx]   = tgt;
      end else begin
         m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
      end
      m_bc = m_bc + 1;
      if (mis) m_mc = m_mc + 1;
   endfunction

   function automatic logic model_taken(input logic [31:0] pc);
      int idx;
      idx = int'(pc[7:2]);
      return m_valid[idx] && (m_tag[idx] == pc[31:8]) && (m_ctr[idx] >= 2);
   endfunction

   function automatic logic [31:0] model_target(input logic [31:0] pc);
      return model_taken(pc) ? m_tgt[int'(pc[7:2])] : pc + 32'd4;
   endfunction

   task automatic apply(input logic [31:0] f, input logic br, input logic tk, input logic mis,
                        input logic [31:0] epc, input logic [31:0] etgt);
      fetch_pc = f; is_branch = br; branch_taken = tk; mispredict = mis;
      exec_pc = epc; exec_target = etgt;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else     model_update(is_branch, branch_taken, mispredict, exec_pc, exec_target);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      apply(32'h0, 0, 0, 0, 32'h0, 32'h0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      apply(32'h100, 0, 0, 0, 32'h0, 32'h0);
      tick();
      #1;
      total++; if (predict_taken !== 1'b0) $display("FAIL reset_in_taken: got %b expected 0", predict_taken); else passed++;
      total++; if (predict_target !== 32'h104) $display("FAIL reset_in_target: got %h expected 00000104", predict_target); else passed++;
      rst = 1'b0;
      tick();
      #1;
      total++; if (predict_target !== 32'h104) $display("FAIL reset_target: got %h expected 00000104", predict_target); else passed++;
      total++; if (branch_count !== 32'h0) $display("FAIL reset_bc: got %h expected 00000000", branch_count); else passed++;
      total++; if (mispredict_count !== 32'h0) $display("FAIL reset_mc: got %h expected 00000000", mispredict_count); else passed++;
      fetch_pc = 32'hFFFF_FFFC;
      #1;
      total++; if (predict_target !== 32'h0) $display("FAIL wrap_target: got %h expected 00000000", predict_target); else passed++;
   endtask

   task automatic test_train_taken();
      do_reset();
      apply(32'h100, 1, 1, 0, 32'h100, 32'h200);
      #1;
      // Same-cycle read of the index being written still sees the old entry.
      total++; if (predict_taken !== 1'b0) $display("FAIL nobypass_taken: got %b expected 0", predict_taken); else passed++;
      tick();
      apply(32'h100, 0, 0, 0, 32'h0, 32'h0);
      #1;
      total++; if (predict_taken !== 1'b1) $display("FAIL train_taken: got %b expected 1", predict_taken); else passed++;
      total++; if (predict_target !== 32'h200) $display("FAIL train_target: got %h expected 00000200", predict_target); else passed++;
   endtask

   task automatic test_saturation();
      do_reset();
      repeat (3) begin
         apply(32'h100, 1, 1, 0, 32'h100, 32'h200);
         tick();
      end
      apply(32'h100, 1, 0, 1, 32'h100, 32'h0);
      tick();
      #1;
      total++; if (predict_taken !== 1'b1) $display("FAIL sat_one_nt_taken: got %b expected 1", predict_taken); else passed++;
      total++; if (predict_target !== 32'h200) $display("FAIL sat_one_nt_target: got %h expected 00000200", predict_target); else passed++;
      apply(32'h100, 1, 0, 1, 32'h100, 32'h0);
      tick();
      #1;
      total++; if (predict_taken !== 1'b0) $display("FAIL sat_two_nt_taken: got %b expected 0", predict_taken); else passed++;
      total++; if (predict_target !== 32'h104) $display("FAIL sat_two_nt_target: got %h expected 00000104", predict_target); else passed++;
      repeat (3) begin
         apply(32'h100, 1, 0, 0, 32'h100, 32'h0);
         tick();
      end
      apply(32'h100, 1, 1, 0, 32'h100, 32'h200);
      tick();
      #1;
      total++; if (predict_taken !== 1'b0) $display("FAIL sat_floor_taken: got %b expected 0", predict_taken); else passed++;
   endtask

   task automatic test_alias();
      do_reset();
      apply(32'h100, 1, 1, 0, 32'h100, 32'h200);
      tick();
      fetch_pc = 32'h1100;
      is_branch = 1'b0;
      #1;
      total++; if (predict_taken !== 1'b0) $display("FAIL alias_miss_taken: got %b expected 0", predict_taken); else passed++;
      total++; if (predict_target !== 32'h1104) $display("FAIL alias_miss_target: got %h expected 00001104", predict_target); else passed++;
      apply(32'h1100, 1, 1, 0, 32'h1100, 32'h300);
      tick();
      apply(32'h100, 0, 0, 0, 32'h0, 32'h0);
      #1;
      total++; if (predict_taken !== 1'b0) $display("FAIL alias_old_taken: got %b expected 0", predict_taken); else passed++;
      total++; if (predict_target !== 32'h104) $display("FAIL alias_old_target: got %h expected 00000104", predict_target); else passed++;
      fetch_pc = 32'h1100;
      #1;
      total++; if (predict_target !== 32'h300) $display("FAIL alias_new_target: got %h expected 00000300", predict_target); else passed++;
   endtask

   task automatic test_stats();
      logic [4:0] mis_pat;
      mis_pat = 5'b00101;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         apply(32'h40 + 32'(i * 4), 1, 1'($urandom), mis_pat[i], 32'h80 + 32'(i * 4), $urandom);
         tick();
      end
      apply(32'h40, 0, 1, 1, 32'h80, 32'h0);
      tick();
      #1;
      total++; if (branch_count !== 32'd5) $display("FAIL stats_bc: got %0d expected 5", branch_count); else passed++;
      total++; if (mispredict_count !== 32'd2) $display("FAIL stats_mc: got %0d expected 2", mispredict_count); else passed++;
      force dut.branch_count = 32'hFFFF_FFFF;
      force dut.mispredict_count = 32'hFFFF_FFFF;
      #1;
      release dut.branch_count;
      release dut.mispredict_count;
      apply(32'h40, 1, 0, 1, 32'h80, 32'h0);
      tick();
      #1;
      total++; if (branch_count !== 32'h0) $display("FAIL stats_bc_wrap: got %h expected 00000000", branch_count); else passed++;
      total++; if (mispredict_count !== 32'h0) $display("FAIL stats_mc_wrap: got %h expected 00000000", mispredict_count); else passed++;
   endtask

   task automatic test_reset_priority();
      do_reset();
      apply(32'h40, 1, 1, 1, 32'h40, 32'h80);
      tick();
      rst = 1'b1;
      apply(32'h100, 1, 1, 1, 32'h100, 32'h200);
      tick();
      rst = 1'b0;
      apply(32'h100, 0, 0, 0, 32'h0, 32'h0);
      #1;
      total++; if (predict_taken !== 1'b0) $display("FAIL rstprio_taken: got %b expected 0", predict_taken); else passed++;
      total++; if (branch_count !== 32'h0) $display("FAIL rstprio_bc: got %h expected 00000000", branch_count); else passed++;
      total++; if (mispredict_count !== 32'h0) $display("FAIL rstprio_mc: got %h expected 00000000", mispredict_count); else passed++;
   endtask

   task automatic test_random();
      logic [31:0] pool [8];
      do_reset();
      for (int i = 0; i < 8; i++)
         pool[i] = {(i < 4) ? 24'h000005 : 24'h0A0009, 6'(i % 4), 2'b00};
      for (int n = 0; n < 400; n++) begin
         apply(pool[$urandom_range(7)], 1'($urandom_range(3) != 0), 1'($urandom),
               1'($urandom), pool[$urandom_range(7)], $urandom);
         #1;
         total++;
         if (predict_taken !== model_taken(fetch_pc))
            $display("FAIL rand_taken: pc %h got %b expected %b", fetch_pc, predict_taken, model_taken(fetch_pc));
         else passed++;
         total++;
         if (predict_target !== model_target(fetch_pc))
            $display("FAIL rand_target: pc %h got %h expected %h", fetch_pc, predict_target, model_target(fetch_pc));
         else passed++;
         tick();
         #1;
         total++; if (branch_count !== m_bc) $display("FAIL rand_bc: got %h expected %h", branch_count, m_bc); else passed++;
         total++; if (mispredict_count !== m_mc) $display("FAIL rand_mc: got %h expected %h", mispredict_count, m_mc); else passed++;
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_train_taken();
      test_saturation();
      test_alias();
      test_stats();
      test_reset_priority();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
